// File: rtl/dds_freq_meter.sv
// DDS frequency meter: times 2^PeriodCntLog2 rising midscale crossings, then
// divides a fixed numerator by the cycle total to recover the tuning word.
//   state  | meaning
//   IDLE   | waiting for a crossing with MeasEn high
//   COUNT  | accumulating cycles across the averaged periods
//   DIVIDE | restoring divide, one quotient bit per cycle
//   REPORT | FreqValid pulse with the freshly loaded FreqWord
module dds_freq_meter #(
  parameter int DataInBitWidth    = 10,
  parameter int FrequencyBitWidth = 32,
  parameter int PeriodCntLog2     = 4,
  parameter int CountBitWidth     = 24,
  parameter int Hysteresis        = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         MeasEn,
  input  logic [DataInBitWidth-1:0]    WaveDataIn,
  output logic [FrequencyBitWidth-1:0] FreqWord,
  output logic                         FreqValid,
  output logic                         Timeout,
  output logic                         Busy
);
  localparam int AccW    = CountBitWidth + PeriodCntLog2;
  localparam int RemW    = AccW + 1;
  localparam int QuoW    = FrequencyBitWidth + PeriodCntLog2 + 1;
  localparam int DivCntW = $clog2(QuoW);
  localparam int Mid     = 2 ** (DataInBitWidth - 1);
  localparam int FullSc  = 2 ** DataInBitWidth - 1;
  localparam int LoInt   = (Mid - Hysteresis < 0) ? 0 : Mid - Hysteresis;
  localparam int HiInt   = (Mid + Hysteresis > FullSc) ? FullSc : Mid + Hysteresis;
  localparam logic [DataInBitWidth-1:0] LoThr = LoInt[DataInBitWidth-1:0];
  localparam logic [DataInBitWidth-1:0] HiThr = HiInt[DataInBitWidth-1:0];
  localparam logic [PeriodCntLog2:0]    PcDone = {1'b1, {PeriodCntLog2{1'b0}}};
  localparam logic [DivCntW-1:0]        DivLast = DivCntW'(QuoW - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] COUNT  = 2'd1;
  localparam logic [1:0] DIVIDE = 2'd2;
  localparam logic [1:0] REPORT = 2'd3;

  logic [1:0]                   state_q, state_d;
  logic [DataInBitWidth-1:0]    s_q;
  logic                         above_q, above_d;
  logic [CountBitWidth-1:0]     cnt_q, cnt_d;
  logic [AccW-1:0]              acc_q, acc_d;
  logic [PeriodCntLog2:0]       pc_q, pc_d;
  logic [AccW-1:0]              div_q, div_d;
  logic [AccW-1:0]              rem_q, rem_d;
  logic [QuoW-1:0]              quo_q, quo_d;
  logic [DivCntW-1:0]           dcnt_q, dcnt_d;
  logic [FrequencyBitWidth-1:0] word_q, word_d;
  logic                         valid_q, valid_d;
  logic                         to_q, to_d;

  logic                         x_evt;
  logic                         cnt_max;
  logic [AccW-1:0]              acc_sum;
  logic [PeriodCntLog2:0]       pc_inc;
  logic [RemW-1:0]              rem_sh, rem_sub, rem_sel;
  logic                         rem_ge;
  logic [QuoW-1:0]              quo_nx;
  logic [FrequencyBitWidth-1:0] quo_sat;

  always_comb begin
    x_evt   = !above_q && (s_q >= HiThr);
    above_d = above_q;
    if (s_q < LoThr) begin
      above_d = 1'b0;
    end else if (x_evt) begin
      above_d = 1'b1;
    end
  end

  // Numerator is a single one at bit QuoW-1, so only the first shifted-in bit is set.
  always_comb begin
    cnt_max = &cnt_q;
    acc_sum = acc_q + AccW'(cnt_q);
    pc_inc  = pc_q + 1'b1;
    rem_sh  = {rem_q, (dcnt_q == '0)};
    rem_sub = rem_sh - {1'b0, div_q};
    rem_ge  = (rem_sh >= {1'b0, div_q});
    rem_sel = rem_ge ? rem_sub : rem_sh;
    quo_nx  = {quo_q[QuoW-2:0], rem_ge};
    quo_sat = (|quo_nx[QuoW-1:FrequencyBitWidth]) ? '1 : quo_nx[FrequencyBitWidth-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    pc_d    = pc_q;
    div_d   = div_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dcnt_d  = dcnt_q;
    word_d  = word_q;
    valid_d = 1'b0;
    to_d    = 1'b0;
    if (!MeasEn) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      pc_d    = '0;
      dcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (x_evt) begin
            state_d = COUNT;
            cnt_d   = CountBitWidth'(1);
            acc_d   = '0;
            pc_d    = '0;
          end else if (cnt_max) begin
            cnt_d   = '0;
            word_d  = '0;
            valid_d = 1'b1;
            to_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        COUNT: begin
          if (x_evt) begin
            cnt_d = CountBitWidth'(1);
            acc_d = acc_sum;
            pc_d  = pc_inc;
            if (pc_inc == PcDone) begin
              state_d = DIVIDE;
              div_d   = acc_sum;
              rem_d   = '0;
              quo_d   = '0;
              dcnt_d  = '0;
            end
          end else if (cnt_max) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            pc_d    = '0;
            word_d  = '0;
            valid_d = 1'b1;
            to_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DIVIDE: begin
          if (x_evt) cnt_d = CountBitWidth'(1);
          rem_d  = AccW'(rem_sel);
          quo_d  = quo_nx;
          dcnt_d = dcnt_q + 1'b1;
          if (dcnt_q == DivLast) begin
            state_d = REPORT;
            word_d  = quo_sat;
            valid_d = 1'b1;
          end
        end
        default: begin
          if (x_evt) cnt_d = CountBitWidth'(1);
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      above_q <= 1'b1;
      cnt_q   <= '0;
      acc_q   <= '0;
      pc_q    <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dcnt_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= WaveDataIn;
      above_q <= above_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      pc_q    <= pc_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dcnt_q  <= dcnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      to_q    <= to_d;
    end
  end

  assign FreqWord  = word_q;
  assign FreqValid = valid_q;
  assign Timeout   = to_q;
  assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dds_freq_meter.sv
// Scoreboard bench for dds_freq_meter: directed waveforms push expected results,
// a negedge monitor pops and compares on every FreqValid pulse.
module tb_dds_freq_meter;
  typedef struct {
    logic [31:0] word;
    logic        to;
    int          interval;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        meas_a = 1'b0, meas_b = 1'b0;
  logic [9:0]  wave_a = 10'd512, wave_b = 10'd512;
  logic [31:0] word_a, word_b;
  logic        val_a, val_b, to_a, to_b, busy_a, busy_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   x_total = 0;
  int   xb = 0;
  int   mode_a = 0, mode_b = 0;
  logic [31:0] step_a = 32'h0, step_b = 32'h0;
  logic [31:0] ph_a = 32'h0, ph_b = 32'h0;
  int   sq_pos = 0, sq_len = 187;
  int   sine_tab[256];
  int   small_tab[256];

  dds_freq_meter u_dut_a (
    .clk(clk), .rst_n(rst_n), .MeasEn(meas_a), .WaveDataIn(wave_a),
    .FreqWord(word_a), .FreqValid(val_a), .Timeout(to_a), .Busy(busy_a)
  );

  dds_freq_meter #(.CountBitWidth(12)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .MeasEn(meas_b), .WaveDataIn(wave_b),
    .FreqWord(word_b), .FreqValid(val_b), .Timeout(to_b), .Busy(busy_b)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] gen(input int mode, input logic [31:0] ph, input int sp);
    int k, v;
    k = int'(ph[31:24]);
    case (mode)
      1: v = sine_tab[k];
      2: v = (sp < 93) ? 0 : 1023;
      3: v = sine_tab[k] + ((k * 37 + 11) % 13) - 6;
      4: v = small_tab[k];
      default: v = 512;
    endcase
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    return 10'(v);
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    ph_a = ph_a + step_a;
    ph_b = ph_b + step_b;
    sq_pos = (sq_pos == sq_len - 1) ? 0 : sq_pos + 1;
    if (sq_pos == 0) sq_len = (sq_len == 187) ? 188 : 187;
    wave_a = gen(mode_a, ph_a, sq_pos);
    wave_b = gen(mode_b, ph_b, sq_pos);
  end

  // Monitor: independent crossing model on instance A's input, plus scoreboards.
  initial begin
    int   s_m, last_a, last_b;
    logic above_m, xm;
    exp_t e;
    s_m = 0; above_m = 1'b1; last_a = 0; last_b = 0;
    forever begin
      @(negedge clk);
      cyc++;
      xm = !above_m && (s_m >= 520);
      if (s_m < 504) above_m = 1'b0;
      else if (xm) above_m = 1'b1;
      if (xm && meas_a) x_total++;
      s_m = int'(wave_a);
      if (val_a) begin
        if (q_a.size() == 0) chk("a_unexpected_valid", 32'(val_a), 32'(0));
        else begin
          e = q_a.pop_front();
          chk("a_word", word_a, e.word);
          chk("a_timeout", 32'(to_a), 32'(e.to));
          if (e.interval != 0) chk("a_interval", 32'(cyc - last_a), 32'(e.interval));
        end
        last_a = cyc;
      end
      if (to_a) chk("a_timeout_has_valid", 32'(val_a), 32'(1));
      if (val_b) begin
        if (q_b.size() == 0) chk("b_unexpected_valid", 32'(val_b), 32'(0));
        else begin
          e = q_b.pop_front();
          chk("b_word", word_b, e.word);
          chk("b_timeout", 32'(to_b), 32'(e.to));
          if (e.interval != 0) chk("b_interval", 32'(cyc - last_b), 32'(e.interval));
        end
        last_b = cyc;
      end
      if (to_b) chk("b_timeout_has_valid", 32'(val_b), 32'(1));
    end
  end

  task automatic push_a(input logic [31:0] w, input logic t, input int iv);
    exp_t e;
    e.word = w; e.to = t; e.interval = iv;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic [31:0] w, input logic t, input int iv);
    exp_t e;
    e.word = w; e.to = t; e.interval = iv;
    q_b.push_back(e);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((q_a.size() + q_b.size()) != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("scoreboard_drain", 32'(q_a.size() + q_b.size()), 32'(0));
    q_a.delete();
    q_b.delete();
    #1;
  endtask

  task automatic wait_x(input int n);
    int k;
    k = 0;
    while ((x_total - xb) < n && k < 8000) begin
      @(posedge clk);
      k++;
    end
    chk("crossings_seen", 32'(x_total - xb), 32'(n));
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    for (int k = 0; k < 256; k++) begin
      real a;
      a = 2.0 * 3.14159265358979 * k / 256.0;
      sine_tab[k]  = int'($floor(511.5 + 511.5 * $sin(a) + 0.5));
      if (sine_tab[k] > 1023) sine_tab[k] = 1023;
      small_tab[k] = 512 + int'($floor(6.0 * $sin(a) + 0.5));
    end

    idle_cycles(3);
    chk("reset_word", word_a, 32'h0);
    chk("reset_valid", 32'(val_a), 32'(0));
    chk("reset_timeout", 32'(to_a), 32'(0));
    chk("reset_busy", 32'(busy_a), 32'(0));
    chk("reset_word_b", word_b, 32'h0);
    rst_n = 1'b1;

    // 256-cycle sine: latency from the 17th crossing, then a repeat measurement
    mode_a = 1; step_a = 32'h0100_0000;
    idle_cycles(300);
    push_a(32'h0100_0000, 1'b0, 0);
    push_a(32'h0100_0000, 1'b0, 0);
    meas_a = 1'b1; xb = x_total;
    wait_x(17);
    lat = 0;
    for (int i = 1; i <= 60 && lat == 0; i++) begin
      @(negedge clk);
      if (val_a) lat = i;
    end
    chk("latency_after_last_crossing", 32'(lat), 32'(38));
    drain(12000);
    meas_a = 1'b0;

    step_a = 32'h0200_0000;
    idle_cycles(300);
    push_a(32'h0200_0000, 1'b0, 0);
    push_a(32'h0200_0000, 1'b0, 0);
    meas_a = 1'b1;
    drain(7000);
    meas_a = 1'b0;

    mode_a = 2;
    idle_cycles(400);
    push_a(32'h015D_867C, 1'b0, 0);
    push_a(32'h015D_867C, 1'b0, 0);
    meas_a = 1'b1;
    drain(9000);
    meas_a = 1'b0;

    mode_a = 3; step_a = 32'h0100_0000;
    idle_cycles(300);
    push_a(32'h0100_0000, 1'b0, 0);
    meas_a = 1'b1;
    drain(6000);
    meas_a = 1'b0;

    // MeasEn dropped mid-COUNT
    mode_a = 1;
    idle_cycles(300);
    meas_a = 1'b1; xb = x_total;
    wait_x(5);
    chk("busy_in_count", 32'(busy_a), 32'(1));
    meas_a = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("busy_after_count_abort", 32'(busy_a), 32'(0));
    idle_cycles(200);
    chk("word_held_count_abort", word_a, 32'h0100_0000);

    // MeasEn dropped mid-DIVIDE
    meas_a = 1'b1; xb = x_total;
    wait_x(17);
    idle_cycles(10);
    chk("busy_in_divide", 32'(busy_a), 32'(1));
    meas_a = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("busy_after_divide_abort", 32'(busy_a), 32'(0));
    idle_cycles(100);
    chk("word_held_divide_abort", word_a, 32'h0100_0000);

    // asynchronous reset mid-DIVIDE
    meas_a = 1'b1; xb = x_total;
    wait_x(17);
    idle_cycles(10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_word", word_a, 32'h0);
    chk("async_rst_valid", 32'(val_a), 32'(0));
    chk("async_rst_timeout", 32'(to_a), 32'(0));
    chk("async_rst_busy", 32'(busy_a), 32'(0));
    meas_a = 1'b0;
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(100);

    // 12-bit counter instance: a real measurement, then timeouts
    mode_b = 1; step_b = 32'h0200_0000;
    idle_cycles(300);
    push_b(32'h0200_0000, 1'b0, 0);
    meas_b = 1'b1;
    drain(5000);
    meas_b = 1'b0;

    mode_b = 0;
    idle_cycles(20);
    push_b(32'h0, 1'b1, 0);
    push_b(32'h0, 1'b1, 4096);
    meas_b = 1'b1;
    drain(10000);
    meas_b = 1'b0;

    mode_b = 4; step_b = 32'h0100_0000;
    idle_cycles(20);
    push_b(32'h0, 1'b1, 0);
    push_b(32'h0, 1'b1, 4096);
    meas_b = 1'b1;
    drain(10000);
    meas_b = 1'b0;
    idle_cycles(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
